ex_stage_mc: RTL and testbench

Parametrised execute stage for the pipelined processor, with the EX/MEM pipeline register built in. Contains:
- forwarding selection for both operands;
- ALU-source and destination-register selection;
- ALU control decode;
- branch-target adder;
- an iterative multi-cycle multiply/divide unit that stalls the upstream pipeline through a busy handshake.

It sits between ID/EX and MEM, and the hazard unit consumes ex_stall.

---
 rtl/ex_pkg.sv | 29 ++
 rtl/ex_stage_mc_muldiv.sv | 81 ++++++++
 rtl/ex_stage_mc.sv | 125 ++++++++++++
 tb/tb_ex_stage_mc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op, funct, forwarding selects
// and the multi-cycle unit state.
package ex_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ORI   = 2'b11;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_SLT = 3'b100;
  localparam logic [2:0] FN_SLL = 3'b101;
  localparam logic [2:0] FN_MUL = 3'b110;
  localparam logic [2:0] FN_DIV = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } mdState_e;

endpackage

// File: rtl/ex_stage_mc_muldiv.sv
// Iterative multiply (shift-add, low half) / unsigned restoring divide.
// One step per cycle for DATA_W cycles; result held while done is high.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              abort,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  mdState_e          state;
  logic [CNT_W-1:0]  cnt;
  logic              isDiv;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] qReg;
  logic [DATA_W-1:0] bReg;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              ge;

  // acc doubles as product accumulator (mul) and partial remainder (div)
  always_comb begin
    shifted = {acc, qReg[DATA_W-1]};
    diff    = shifted - {1'b0, bReg};
    ge      = (shifted >= {1'b0, bReg});
  end

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state <= MD_IDLE;
      cnt   <= '0;
      isDiv <= 1'b0;
      acc   <= '0;
      qReg  <= '0;
      bReg  <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= '0;
            isDiv <= op;
            acc   <= '0;
            qReg  <= op ? a : b;
            bReg  <= op ? b : a;
          end
        end
        MD_BUSY: begin
          if (isDiv) begin
            acc  <= ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
            qReg <= {qReg[DATA_W-2:0], ge};
          end else begin
            acc  <= acc + (qReg[0] ? bReg : '0);
            bReg <= bReg << 1;
            qReg <= qReg >> 1;
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) state <= MD_DONE;
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy   = (state == MD_BUSY);
  assign done   = (state == MD_DONE);
  assign result = isDiv ? qReg : acc;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with forwarding, ALU, branch-target adder, iterative mul/div
// and the EX/MEM pipeline register.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_W     = 3,
  parameter int unsigned BR_SHIFT  = 1,
  parameter bit          MULDIV_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              ex_flush,
  input  logic [DATA_W-1:0] pc_next,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_W-1:0]  rt_addr,
  input  logic [REG_W-1:0]  rd_addr,
  input  logic              alu_src,
  input  logic [1:0]        alu_op,
  input  logic              reg_dest,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic [DATA_W-1:0] fwd_wb_data,
  output logic              ex_stall,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_zero,
  output logic [DATA_W-1:0] mem_branch_target
);

  logic [DATA_W-1:0] opA, opBf, opB;
  logic [DATA_W-1:0] aluResult, unitResult, finalResult;
  logic [2:0]        funct;
  logic              isMulDivFn, mdBusy, mdDone, mdIdle;

  assign funct = imm[2:0];

  always_comb begin
    case (fwd_a)
      FWD_MEM: opA = fwd_mem_data;
      FWD_WB:  opA = fwd_wb_data;
      default: opA = rs_data;
    endcase
    case (fwd_b)
      FWD_MEM: opBf = fwd_mem_data;
      FWD_WB:  opBf = fwd_wb_data;
      default: opBf = rt_data;
    endcase
    opB = alu_src ? imm : opBf;
  end

  always_comb begin
    aluResult = '0;
    case (alu_op)
      ALU_ADD: aluResult = opA + opB;
      ALU_SUB: aluResult = opA - opB;
      ALU_ORI: aluResult = opA | opB;
      default: begin
        case (funct)
          FN_ADD:  aluResult = opA + opB;
          FN_SUB:  aluResult = opA - opB;
          FN_AND:  aluResult = opA & opB;
          FN_OR:   aluResult = opA | opB;
          FN_SLT:  aluResult = {{(DATA_W-1){1'b0}}, ($signed(opA) < $signed(opB))};
          FN_SLL:  aluResult = opA << opB[3:0];
          default: aluResult = '0;
        endcase
      end
    endcase
  end

  assign isMulDivFn  = (alu_op == ALU_RTYPE) && (funct == FN_MUL || funct == FN_DIV);
  assign mdIdle      = !mdBusy && !mdDone;
  // Flush overrides stall; a unit sitting in DONE releases the stall for one cycle
  assign ex_stall    = !ex_flush && (mdBusy || (mdIdle && in_valid && isMulDivFn && MULDIV_EN));
  assign finalResult = isMulDivFn ? unitResult : aluResult;

  generate
    if (MULDIV_EN) begin : gMulDiv
      logic mdStart;
      assign mdStart = ex_stall && !mdBusy;
      muldiv_iter #(.DATA_W(DATA_W)) uMulDiv (
        .clock  (clock),
        .reset  (reset),
        .abort  (ex_flush),
        .start  (mdStart),
        .op     (funct[0]),
        .a      (opA),
        .b      (opBf),
        .busy   (mdBusy),
        .done   (mdDone),
        .result (unitResult)
      );
    end else begin : gNoMulDiv
      assign mdBusy     = 1'b0;
      assign mdDone     = 1'b0;
      assign unitResult = '0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_valid         <= 1'b0;
      mem_alu_result    <= '0;
      mem_store_data    <= '0;
      mem_rd            <= '0;
      mem_zero          <= 1'b0;
      mem_branch_target <= '0;
    end else begin
      mem_valid         <= in_valid && !ex_flush && !ex_stall;
      mem_alu_result    <= finalResult;
      mem_store_data    <= opBf;
      mem_rd            <= reg_dest ? rd_addr : rt_addr;
      mem_zero          <= (finalResult == '0);
      mem_branch_target <= pc_next + (imm << BR_SHIFT);
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed self-checking bench for ex_stage_mc (plus a MULDIV_EN=0 instance).
module tb_ex_stage_mc;
  import ex_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;

  logic          clock = 1'b0;
  logic          reset, in_valid, ex_flush, alu_src, reg_dest;
  logic [DW-1:0] pc_next, rs_data, rt_data, imm, fwd_mem_data, fwd_wb_data;
  logic [RW-1:0] rt_addr, rd_addr;
  logic [1:0]    alu_op, fwd_a, fwd_b;

  logic          ex_stall, mem_valid, mem_zero;
  logic [DW-1:0] mem_alu_result, mem_store_data, mem_branch_target;
  logic [RW-1:0] mem_rd;

  logic          stallN, validN, zeroN;
  logic [DW-1:0] resultN, storeN, targetN;
  logic [RW-1:0] rdN;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ex_stage_mc #(.DATA_W(DW), .REG_W(RW), .BR_SHIFT(1), .MULDIV_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .ex_flush(ex_flush),
    .pc_next(pc_next), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .alu_src(alu_src), .alu_op(alu_op),
    .reg_dest(reg_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .ex_stall(ex_stall), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_zero(mem_zero),
    .mem_branch_target(mem_branch_target)
  );

  ex_stage_mc #(.DATA_W(DW), .REG_W(RW), .BR_SHIFT(1), .MULDIV_EN(1'b0)) dutNoMd (
    .clock(clock), .reset(reset), .in_valid(in_valid), .ex_flush(ex_flush),
    .pc_next(pc_next), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .alu_src(alu_src), .alu_op(alu_op),
    .reg_dest(reg_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .ex_stall(stallN), .mem_valid(validN), .mem_alu_result(resultN),
    .mem_store_data(storeN), .mem_rd(rdN), .mem_zero(zeroN),
    .mem_branch_target(targetN)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] rs,
                       input logic [DW-1:0] rt, input logic [DW-1:0] im, input logic src);
    in_valid = 1'b1;
    alu_op   = op;
    rs_data  = rs;
    rt_data  = rt;
    imm      = im;
    alu_src  = src;
    fwd_a    = FWD_REG;
    fwd_b    = FWD_REG;
  endtask

  task automatic checkAllZero(input string tag);
    checkEq({tag, "_stall"},  ex_stall, 0);
    checkEq({tag, "_valid"},  mem_valid, 0);
    checkEq({tag, "_result"}, mem_alu_result, 0);
    checkEq({tag, "_store"},  mem_store_data, 0);
    checkEq({tag, "_rd"},     mem_rd, 0);
    checkEq({tag, "_zero"},   mem_zero, 0);
    checkEq({tag, "_target"}, mem_branch_target, 0);
  endtask

  // Count stall cycles, disturb the forwarding sources mid-operation, then check result
  task automatic runMulti(input string tag, input logic [DW-1:0] expRes);
    int   stallCnt = 0;
    logic sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!ex_stall) break;
      stallCnt++;
      if (stallCnt == 6) begin
        fwd_wb_data  = 16'hFFFF;
        fwd_mem_data = 16'hEEEE;
        rs_data      = 16'hAAAA;
        rt_data      = 16'h5555;
      end
      @(posedge clock);
      #1;
      if (mem_valid) sawValid = 1'b1;
    end
    checkEq({tag, "_stall_cycles"}, stallCnt, 17);
    checkEq({tag, "_bubble_valid"}, sawValid, 0);
    tick();
    checkEq({tag, "_valid"}, mem_valid, 1);
    checkEq({tag, "_result"}, mem_alu_result, expRes);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ex_flush = 1'b0; alu_src = 1'b0; reg_dest = 1'b0;
    pc_next = '0; rs_data = '0; rt_data = '0; imm = '0;
    fwd_mem_data = '0; fwd_wb_data = '0; rt_addr = '0; rd_addr = '0;
    alu_op = ALU_ADD; fwd_a = FWD_REG; fwd_b = FWD_REG;
    repeat (2) tick();
    checkAllZero("reset");
    reset = 1'b0;

    // R-type add with A forwarded from MEM
    issue(ALU_RTYPE, 16'h0000, 16'h0003, 16'h0000, 1'b0);
    fwd_a = FWD_MEM; fwd_mem_data = 16'h0005;
    reg_dest = 1'b1; rd_addr = 3'd5; rt_addr = 3'd2;
    #1 checkEq("add_stall", ex_stall, 0);
    tick();
    checkEq("add_result", mem_alu_result, 16'h0008);
    checkEq("add_valid", mem_valid, 1);
    checkEq("add_zero", mem_zero, 0);
    checkEq("add_rd", mem_rd, 5);
    checkEq("add_store", mem_store_data, 16'h0003);

    // beq-style subtract and branch target
    issue(ALU_SUB, 16'h1234, 16'h1234, 16'h0004, 1'b0);
    pc_next = 16'h0010;
    tick();
    checkEq("beq_zero", mem_zero, 1);
    checkEq("beq_result", mem_alu_result, 0);
    checkEq("beq_target", mem_branch_target, 16'h0018);

    // or-immediate, A forwarded from WB, destination rt
    issue(ALU_ORI, 16'h1111, 16'h0000, 16'h000F, 1'b1);
    fwd_a = FWD_WB; fwd_wb_data = 16'h00F0;
    reg_dest = 1'b0; rt_addr = 3'd6;
    tick();
    checkEq("ori_result", mem_alu_result, 16'h00FF);
    checkEq("ori_rd", mem_rd, 6);

    // sll with fwd_a=11 selecting the register value
    issue(ALU_RTYPE, 16'h0003, 16'h0004, 16'h0005, 1'b0);
    fwd_a = 2'b11; fwd_mem_data = 16'h7777;
    tick();
    checkEq("sll_result", mem_alu_result, 16'h0030);

    // and on the single-cycle path
    issue(ALU_RTYPE, 16'h0F0F, 16'h00FF, 16'h0002, 1'b0);
    tick();
    checkEq("and_result", mem_alu_result, 16'h000F);

    // mul with B forwarded from WB; the disabled instance returns 0 without stalling
    issue(ALU_RTYPE, 16'h0123, 16'h0000, 16'h0006, 1'b0);
    fwd_b = FWD_WB; fwd_wb_data = 16'h0010;
    #1 checkEq("nomd_stall", stallN, 0);
    runMulti("mul", 16'h1230);
    checkEq("nomd_valid", validN, 1);
    checkEq("nomd_result", resultN, 0);

    issue(ALU_RTYPE, 16'h0064, 16'h0007, 16'h0007, 1'b0);
    runMulti("div", 16'h000E);

    issue(ALU_RTYPE, 16'h0064, 16'h0000, 16'h0007, 1'b0);
    runMulti("div0", 16'hFFFF);

    // in_valid low loads a bubble
    tick();
    checkEq("idle_valid", mem_valid, 0);

    // flush in BUSY cycle 5
    issue(ALU_RTYPE, 16'h0003, 16'h0005, 16'h0006, 1'b0);
    #1 checkEq("flush_start_stall", ex_stall, 1);
    repeat (5) tick();
    checkEq("flush_busy_stall", ex_stall, 1);
    ex_flush = 1'b1;
    #1 checkEq("flush_stall_low", ex_stall, 0);
    tick();
    checkEq("flush_valid", mem_valid, 0);
    ex_flush = 1'b0;
    issue(ALU_ADD, 16'h0002, 16'h0000, 16'h0007, 1'b1);
    #1 checkEq("post_flush_stall", ex_stall, 0);
    tick();
    checkEq("post_flush_valid", mem_valid, 1);
    checkEq("post_flush_result", mem_alu_result, 16'h0009);

    // reset during BUSY
    pc_next = 16'h0020;
    issue(ALU_RTYPE, 16'h0064, 16'h0007, 16'h0007, 1'b0);
    repeat (3) tick();
    checkEq("rst_busy_stall", ex_stall, 1);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    checkAllZero("rst_busy");
    reset = 1'b0;

    // signed slt
    issue(ALU_RTYPE, 16'h8000, 16'h0001, 16'h0004, 1'b0);
    #1 checkEq("slt_stall", ex_stall, 0);
    tick();
    checkEq("slt_valid", mem_valid, 1);
    checkEq("slt_result", mem_alu_result, 16'h0001);
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
